shift_add_multiplier: RTL and testbench
=======================================

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port in_valid  input  1  operands and mode present on a, b, is_signed.
REQ-005 Port in_ready  output  1  block can accept a new operation.
REQ-006 Port a  input  WIDTH  multiplicand.
REQ-007 Port b  input  WIDTH  multiplier.
REQ-008 Port is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 Port out_valid  output  1  product is valid.
REQ-010 Port out_ready  input  1  consumer accepts product.
REQ-011 Port product  output  2*WIDTH  result of a*b.

Function
REQ-012 Three-state FSM: IDLE, COMPUTE, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 Accept on rising edge with in_valid && in_ready: latch a, b, is_signed; go to COMPUTE with iteration count 0; inputs ignored outside acceptance.
REQ-015 Signed mode: latch magnitudes |a|, |b| as WIDTH-bit unsigned values plus result sign = a[MSB] XOR b[MSB]; unsigned mode: sign 0.
REQ-016 COMPUTE, each edge: if multiplier LSB = 1, add multiplicand into upper WIDTH+1 bits of accumulator; shift {carry, accumulator, multiplier} right one bit; increment count.
REQ-017 After exactly WIDTH COMPUTE edges, go to DONE; out_valid rises on the WIDTH-th edge after acceptance.
REQ-018 product = accumulator, or its two's-complement negation when result sign = 1; result exact modulo 2^(2*WIDTH).
REQ-019 DONE: product and out_valid held stable while out_ready = 0, for any duration.
REQ-020 DONE with out_ready = 1 at an edge: go to IDLE; in_ready = 1 the following cycle (no same-cycle accept-and-retire).
REQ-021 in_valid asserted during COMPUTE or DONE has no effect; source holds it until in_ready.
REQ-022 Zero operand: full WIDTH-cycle latency still applies; product = 0, never negative zero.
REQ-023 Most-negative operand (e.g. -2^(WIDTH-1)) SHALL produce the exact signed product, including (-2^(WIDTH-1))^2.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, in_ready = 1 after deassertion, out_valid = 0, product = 0, count and all datapath registers = 0.
REQ-025 Reset during COMPUTE or DONE SHALL abandon the operation with no out_valid pulse after release.
REQ-026 First acceptance possible on the first rising edge after rst_n deasserts.

Structure
REQ-027 Shared package: FSM state enum (IDLE, COMPUTE, DONE), default WIDTH constant, count-width function clog2(WIDTH+1).
REQ-028 One sub-module, ripple_adder: parametrised WIDTH-bit adder built from the team's existing full_adder cell, carry-out exposed; used for the accumulate step.
REQ-029 Final sign negation SHALL be registered on the COMPUTE->DONE transition, not combinational on product.

Verification
REQ-030 WIDTH=4, unsigned, a=4'hF, b=4'hF -> out_valid after 4 edges, product=8'hE1.
REQ-031 WIDTH=4, signed, a=4'h8 (-8), b=4'h8 (-8) -> product=8'h40; a=4'hF (-1), b=4'h7 -> product=8'hF9.
REQ-032 WIDTH=4, exhaustive all 256 operand pairs in both modes, back-to-back, against a reference model -> zero mismatches, each result latency exactly 4.
REQ-033 WIDTH=8, a=8'd200, b=8'd3, out_ready held low 6 cycles -> product=16'd600 stable, in_ready=0 and out_valid=1 throughout, IDLE one edge after out_ready rises.
REQ-034 WIDTH=8, rst_n pulsed low at count=3 of a COMPUTE -> out_valid=0, product=0, in_ready=1 after release; next operation 5*7 -> 16'd35.
REQ-035 Coverage: every FSM transition, both modes, sign result 0 and 1, backpressure length 0 and >0.

Source files
------------

// File: rtl/shift_add_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module : shift_add_multiplier_pkg
// Brief  : Shared FSM state type, default width and counter sizing helper.
// Rev    : 1.0
// ============================================================================
package shift_add_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Counter must hold 0..WIDTH inclusive.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_add_multiplier_ripple_adder.sv
`default_nettype none
// ============================================================================
// Module : full_adder / ripple_adder
// Brief  : One-bit full adder cell and a WIDTH-bit ripple chain built from it.
// Rev    : 1.0
// ============================================================================
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

module ripple_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    full_adder u_fa (
      .i_a    (i_a[gi]),
      .i_b    (i_b[gi]),
      .i_cin  (w_carry[gi]),
      .o_sum  (o_sum[gi]),
      .o_cout (w_carry[gi+1])
    );
  end

  assign o_cout = w_carry[WIDTH];

endmodule
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module : shift_add_multiplier
// Brief  : Sequential shift-and-add multiplier, signed/unsigned, WIDTH cycles.
// Rev    : 1.0
// ============================================================================
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = count_width(WIDTH);

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [WIDTH-1:0]     r_acc;
  logic                 r_sign;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_product;

  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;
  logic [2*WIDTH-1:0]   w_full;
  logic [2*WIDTH-1:0]   w_final;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_state == COMPUTE) && (r_count == CW'(WIDTH - 1));

  // Magnitudes fit WIDTH unsigned bits, including the most-negative value.
  assign w_a_mag  = (is_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_mag  = (is_signed && b[WIDTH-1]) ? -b : b;

  assign w_addend = r_mplier[0] ? r_mcand : '0;

  ripple_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_a    (r_acc),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Post-shift accumulator/multiplier pair as it stands after the final step.
  assign w_full  = {w_cout, w_sum, r_mplier[WIDTH-1:1]};
  assign w_final = r_sign ? -w_full : w_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_state_next = COMPUTE;
      COMPUTE: if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    product   = r_product;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_sign    <= 1'b0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_acc    <= '0;
            r_sign   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_count  <= '0;
          end
        end
        COMPUTE: begin
          r_acc    <= {w_cout, w_sum[WIDTH-1:1]};
          r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
          r_count  <= r_count + CW'(1);
          if (w_last) begin
            r_product <= w_final;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module : tb_shift_add_multiplier
// Brief  : Directed and exhaustive checks on WIDTH=4 and WIDTH=8 instances.
// Rev    : 1.0
// ============================================================================
module tb_shift_add_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n4, iv4, ir4, s4, ov4, or4;
  logic [3:0] a4, b4;
  logic [7:0] p4;

  logic        rst_n8, iv8, ir8, s8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int errors = 0;
  int checks = 0;

  shift_add_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n4), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .is_signed(s4), .out_valid(ov4),
    .out_ready(or4), .product(p4)
  );

  shift_add_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n8), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .is_signed(s8), .out_valid(ov8),
    .out_ready(or8), .product(p8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic s);
    int xi, yi;
    xi = s ? int'($signed(x)) : int'(x);
    yi = s ? int'($signed(y)) : int'(y);
    return 8'(xi * yi);
  endfunction

  // Called just after a negedge; returns just after a negedge with block idle.
  task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic s,
                     output logic [7:0] p, output int lat);
    check("ir4_before_op", ir4, 1);
    a4 = x; b4 = y; s4 = s; iv4 = 1'b1;
    @(posedge clk); @(negedge clk);
    iv4 = 1'b0; a4 = ~x; b4 = ~y;
    lat = 0;
    while (!ov4 && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    p = p4;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic s,
                     output logic [15:0] p, output int lat);
    check("ir8_before_op", ir8, 1);
    a8 = x; b8 = y; s8 = s; iv8 = 1'b1;
    @(posedge clk); @(negedge clk);
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 30) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    p = p8;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    logic [7:0]  r4;
    logic [15:0] r8;
    int          lat;
    logic        saw;

    rst_n4 = 1'b0; rst_n8 = 1'b0;
    iv4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; or4 = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; or8 = 1'b1;
    #17;
    check("rst_ir4", ir4, 1);
    check("rst_ov4", ov4, 0);
    check("rst_p4",  p4,  0);
    check("rst_ov8", ov8, 0);
    check("rst_p8",  p8,  0);
    @(negedge clk);
    rst_n4 = 1'b1; rst_n8 = 1'b1;

    // First accept on the first edge after release.
    op4(4'hF, 4'hF, 1'b0, r4, lat);
    check("u_F_F_prod", r4, 8'hE1);
    check("u_F_F_lat",  lat, 4);
    op4(4'h8, 4'h8, 1'b1, r4, lat);
    check("s_m8_m8_prod", r4, 8'h40);
    op4(4'hF, 4'h7, 1'b1, r4, lat);
    check("s_m1_7_prod", r4, 8'hF9);
    op4(4'h0, 4'hD, 1'b1, r4, lat);
    check("s_0_m3_prod", r4, 8'h00);
    check("s_0_m3_lat",  lat, 4);

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          op4(4'(i), 4'(j), 1'(s), r4, lat);
          check("exh_prod", r4, ref4(4'(i), 4'(j), 1'(s)));
          check("exh_lat",  lat, 4);
        end
      end
    end

    op8(8'h80, 8'h80, 1'b1, r8, lat);
    check("s8_m128_sq", r8, 16'h4000);
    check("s8_m128_lat", lat, 8);
    op8(8'hFF, 8'h7F, 1'b1, r8, lat);
    check("s8_m1_127", r8, 16'hFF81);
    op8(8'h00, 8'h80, 1'b1, r8, lat);
    check("s8_0_m128", r8, 16'h0000);
    check("s8_0_lat",  lat, 8);
    op8(8'hFF, 8'hFF, 1'b0, r8, lat);
    check("u8_FF_FF", r8, 16'hFE01);

    // Backpressure with stray in_valid and changing operands during COMPUTE.
    or8 = 1'b0;
    check("bp_ir8_idle", ir8, 1);
    a8 = 8'd200; b8 = 8'd3; s8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); @(negedge clk);
    a8 = 8'd1; b8 = 8'd1; s8 = 1'b1;
    lat = 0;
    while (!ov8 && lat < 30) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    iv8 = 1'b0;
    check("bp_lat",  lat, 8);
    check("bp_prod", p8, 16'd600);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      check("bp_hold_ov", ov8, 1);
      check("bp_hold_ir", ir8, 0);
      check("bp_hold_p",  p8, 16'd600);
    end
    or8 = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bp_retire_ir", ir8, 1);
    check("bp_retire_ov", ov8, 0);

    // Reset mid-COMPUTE, after three compute edges.
    a8 = 8'd9; b8 = 8'd9; s8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n8 = 1'b0;
    #1;
    check("arst_ov8", ov8, 0);
    check("arst_p8",  p8, 0);
    check("arst_ir8", ir8, 1);
    @(negedge clk);
    rst_n8 = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); @(negedge clk);
      if (ov8) saw = 1'b1;
    end
    check("arst_no_ov", saw, 0);
    check("arst_p8_after", p8, 0);
    op8(8'd5, 8'd7, 1'b0, r8, lat);
    check("post_rst_5x7", r8, 16'd35);
    check("post_rst_lat", lat, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
